// File: rtl/mio_arbiter.sv
// mio_arbiter: round-robin arbiter and access sequencer for the shared
// memory / memory-mapped I/O port. Requester 0 is the CPU bus interface,
// requester 1 is the DMA/UART boot-loader engine. Each granted access runs
// MAR load, optional MDR load, MIO_EN strobe until R, optional MDR readback,
// and is aborted with err after TIMEOUT access cycles without R.
// Control outputs are registered: they are computed from the next state
// and the next latched fields, so each one changes on the same edge as the
// state it belongs to.
module mio_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        err,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic [15:0] bus_in,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        gate_mdr,
  output logic        mio_en,
  output logic        r_w,
  input  logic        r
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_ACCESS = 3'd3,
    S_READ   = 3'd4,
    S_ACK    = 3'd5
  } state_t;

  localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

  state_t      state, state_nx;
  logic        last, last_nx;         // index of the previous winner
  logic        owner, owner_nx;       // index of the current owner
  logic        we_l, we_nx;
  logic [15:0] addr_l, addr_nx;
  logic [15:0] wdata_l, wdata_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        err_flag, err_flag_nx;
  logic [8:0]  cnt_inc;

  // Registered-output next values
  logic [15:0] bus_out_nx;
  logic        bus_oe_nx, ld_mar_nx, ld_mdr_nx, gate_mdr_nx;
  logic        mio_en_nx, r_w_nx, ack0_nx, ack1_nx, err_nx, busy_nx;
  logic [1:0]  grant_nx;

  // Widened so the compare against TIMEOUT cannot wrap.
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  // Next-state, arbitration and latched-field update.
  always_comb begin
    state_nx    = state;
    last_nx     = last;
    owner_nx    = owner;
    we_nx       = we_l;
    addr_nx     = addr_l;
    wdata_nx    = wdata_l;
    cnt_nx      = cnt;
    err_flag_nx = err_flag;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // Both requesting: the one that did not win last time.
          if (req0 && req1) begin
            owner_nx = ~last;
          end else begin
            owner_nx = req1;
          end
          if (owner_nx) begin
            we_nx    = we1;
            addr_nx  = addr1;
            wdata_nx = wdata1;
          end else begin
            we_nx    = we0;
            addr_nx  = addr0;
            wdata_nx = wdata0;
          end
          last_nx  = owner_nx;
          state_nx = S_ADDR;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ADDR: begin
        if (we_l) begin
          state_nx = S_DATA;
        end else begin
          state_nx = S_ACCESS;
        end
      end
      S_DATA: begin
        state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_nx = cnt_inc[7:0];
        if (r) begin
          if (we_l) begin
            state_nx = S_ACK;
          end else begin
            state_nx = S_READ;
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          err_flag_nx = 1'b1;
          state_nx    = S_ACK;
        end else begin
          state_nx = S_ACCESS;
        end
      end
      S_READ: begin
        state_nx = S_ACK;
      end
      S_ACK: begin
        cnt_nx      = 8'd0;
        err_flag_nx = 1'b0;
        state_nx    = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    bus_out_nx  = 16'h0000;
    bus_oe_nx   = 1'b0;
    ld_mar_nx   = 1'b0;
    ld_mdr_nx   = 1'b0;
    gate_mdr_nx = 1'b0;
    mio_en_nx   = 1'b0;
    r_w_nx      = 1'b0;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state_nx)
      S_ADDR: begin
        bus_out_nx = addr_nx;
        bus_oe_nx  = 1'b1;
        ld_mar_nx  = 1'b1;
        // Loading MDR on a read is harmless and keeps it defined.
        ld_mdr_nx  = ~we_nx;
      end
      S_DATA: begin
        bus_out_nx = wdata_nx;
        bus_oe_nx  = 1'b1;
        ld_mdr_nx  = 1'b1;
      end
      S_ACCESS: begin
        mio_en_nx = 1'b1;
        r_w_nx    = we_nx;
      end
      S_READ: begin
        gate_mdr_nx = 1'b1;
      end
      S_ACK: begin
        ack0_nx = ~owner_nx;
        ack1_nx = owner_nx;
        err_nx  = err_flag_nx;
      end
      default: begin
        bus_out_nx = 16'h0000;
      end
    endcase
    if (state_nx != S_IDLE) begin
      busy_nx  = 1'b1;
      grant_nx = owner_nx ? 2'b10 : 2'b01;
    end else begin
      busy_nx  = 1'b0;
      grant_nx = 2'b00;
    end
  end

  // State, arbitration history and latched transaction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_l     <= 1'b0;
      addr_l   <= 16'h0000;
      wdata_l  <= 16'h0000;
      cnt      <= 8'd0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      owner    <= owner_nx;
      we_l     <= we_nx;
      addr_l   <= addr_nx;
      wdata_l  <= wdata_nx;
      cnt      <= cnt_nx;
      err_flag <= err_flag_nx;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out  <= 16'h0000;
      bus_oe   <= 1'b0;
      ld_mar   <= 1'b0;
      ld_mdr   <= 1'b0;
      gate_mdr <= 1'b0;
      mio_en   <= 1'b0;
      r_w      <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      grant    <= 2'b00;
    end else begin
      bus_out  <= bus_out_nx;
      bus_oe   <= bus_oe_nx;
      ld_mar   <= ld_mar_nx;
      ld_mdr   <= ld_mdr_nx;
      gate_mdr <= gate_mdr_nx;
      mio_en   <= mio_en_nx;
      r_w      <= r_w_nx;
      ack0     <= ack0_nx;
      ack1     <= ack1_nx;
      err      <= err_nx;
      busy     <= busy_nx;
      grant    <= grant_nx;
    end
  end

  // Read data captured from the bus at the end of READ; a timed-out read
  // never reaches READ, so it leaves rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 16'h0000;
    end else if (state == S_READ) begin
      rdata <= bus_in;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed self-checking bench for mio_arbiter (built with TIMEOUT=4).
module tb_mio_arbiter;

  logic        clk, rst_n;
  logic        req0, req1, we0, we1, r;
  logic [15:0] addr0, addr1, wdata0, wdata1, bus_in;
  logic        ack0, ack1, err, busy, bus_oe, ld_mar, ld_mdr, gate_mdr, mio_en, r_w;
  logic [15:0] rdata, bus_out;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  // {ld_mar, ld_mdr, gate_mdr, mio_en, r_w, bus_oe, ack0, ack1, err, busy, grant}
  logic [11:0] ctl;
  assign ctl = {ld_mar, ld_mdr, gate_mdr, mio_en, r_w, bus_oe, ack0, ack1, err, busy, grant};

  localparam logic [11:0] C_IDLE    = 12'b0000_0000_0000;
  localparam logic [11:0] C_ADDR_R0 = 12'b1100_0100_0101;
  localparam logic [11:0] C_ACC_R0  = 12'b0001_0000_0101;
  localparam logic [11:0] C_READ0   = 12'b0010_0000_0101;
  localparam logic [11:0] C_ACK0    = 12'b0000_0010_0101;
  localparam logic [11:0] C_ACK0_E  = 12'b0000_0010_1101;
  localparam logic [11:0] C_ADDR_W1 = 12'b1000_0100_0110;
  localparam logic [11:0] C_DATA1   = 12'b0100_0100_0110;
  localparam logic [11:0] C_ACC_W1  = 12'b0001_1000_0110;
  localparam logic [11:0] C_ACK1    = 12'b0000_0001_0110;

  mio_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .grant(grant), .busy(busy),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .gate_mdr(gate_mdr),
    .mio_en(mio_en), .r_w(r_w), .r(r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Release requests and wait (bounded) for the port to go idle.
  task automatic drain;
    int n;
    req0 = 1'b0; req1 = 1'b0; r = 1'b1;
    n = 0;
    step();
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: busy=%b required 0 after %0d cycles", busy, n);
    end
    r = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; r = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    bus_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ctl !== C_IDLE || bus_out !== 16'h0000 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: ctl=%b bus_out=%h rdata=%h required 0", ctl, bus_out, rdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL reset_idle: ctl=%b required %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_single_read;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h3000;
    step(); // t+1 ADDR
    checks++;
    if (ctl !== C_ADDR_R0 || bus_out !== 16'h3000) begin
      errors++;
      $display("FAIL read_addr: ctl=%b bus_out=%h required %b 3000", ctl, bus_out, C_ADDR_R0);
    end
    step(); // t+2 ACCESS
    checks++;
    if (ctl !== C_ACC_R0) begin
      errors++;
      $display("FAIL read_access: ctl=%b required %b", ctl, C_ACC_R0);
    end
    r = 1'b1; bus_in = 16'hBEEF;
    step(); // t+3 READ
    r = 1'b0;
    checks++;
    if (ctl !== C_READ0) begin
      errors++;
      $display("FAIL read_gate: ctl=%b required %b", ctl, C_READ0);
    end
    step(); // t+4 ACK
    checks++;
    if (ctl !== C_ACK0 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_ack: ctl=%b rdata=%h required %b BEEF", ctl, rdata, C_ACK0);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL read_idle: ctl=%b required %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_single_write;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'hFE06; wdata1 = 16'h00A5;
    step(); // ADDR
    checks++;
    if (ctl !== C_ADDR_W1 || bus_out !== 16'hFE06) begin
      errors++;
      $display("FAIL write_addr: ctl=%b bus_out=%h required %b FE06", ctl, bus_out, C_ADDR_W1);
    end
    step(); // DATA
    checks++;
    if (ctl !== C_DATA1 || bus_out !== 16'h00A5) begin
      errors++;
      $display("FAIL write_data: ctl=%b bus_out=%h required %b 00A5", ctl, bus_out, C_DATA1);
    end
    for (int i = 0; i < 3; i++) begin
      step(); // ACCESS cycles 1..3
      if (i == 2) r = 1'b1;
      checks++;
      if (ctl !== C_ACC_W1) begin
        errors++;
        $display("FAIL write_access%0d: ctl=%b required %b", i, ctl, C_ACC_W1);
      end
    end
    step(); // ACK
    r = 1'b0;
    checks++;
    if (ctl !== C_ACK1 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_ack: ctl=%b rdata=%h required %b BEEF", ctl, rdata, C_ACK1);
    end
    req1 = 1'b0;
    step();
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL write_idle: ctl=%b required %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_contention;
    int  last_ack, n_acks;
    logic next_who;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1000;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h2000; wdata1 = 16'h5A5A;
    r = 1'b1; bus_in = 16'h1234;
    last_ack = -100; n_acks = 0; next_who = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        checks++; errors++;
        $display("FAIL contention_both_ack: cycle %0d ack0=1 ack1=1 required one-hot", i);
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        checks++;
        if (i - last_ack < 5) begin
          errors++;
          $display("FAIL contention_spacing: %0d cycles required >=5", i - last_ack);
        end
        checks++;
        if (ack1 !== next_who) begin
          errors++;
          $display("FAIL contention_order: ack1=%b required %b at ack %0d", ack1, next_who, n_acks);
        end
        next_who = ~next_who;
        last_ack = i;
        n_acks++;
      end
    end
    checks++;
    if (n_acks != 6) begin
      errors++;
      $display("FAIL contention_count: %0d acks required 6", n_acks);
    end
    drain();
  endtask

  task automatic test_timeout;
    int  n_mio, n;
    logic seen;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; r = 1'b0; bus_in = 16'h5555;
    n_mio = 0; n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (mio_en === 1'b1) n_mio++;
      if (err === 1'b1 && ack0 !== 1'b1 && ack1 !== 1'b1) begin
        checks++; errors++;
        $display("FAIL timeout_err_alone: err=1 ack0=%b ack1=%b", ack0, ack1);
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (ctl !== C_ACK0_E || rdata !== 16'h1234) begin
          errors++;
          $display("FAIL timeout_ack: ctl=%b rdata=%h required %b 1234", ctl, rdata, C_ACK0_E);
        end
      end
    end
    checks++;
    if (!seen || n_mio != 4) begin
      errors++;
      $display("FAIL timeout_len: ack_seen=%b mio_cycles=%0d required 1 4", seen, n_mio);
    end
    drain();
  endtask

  task automatic test_request_drop;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100; r = 1'b0;
    step(); // ADDR
    checks++;
    if (ctl !== C_ADDR_R0 || bus_out !== 16'h0100) begin
      errors++;
      $display("FAIL drop_addr: ctl=%b bus_out=%h required %b 0100", ctl, bus_out, C_ADDR_R0);
    end
    step(); // ACCESS 1
    req0 = 1'b0;
    step(); // ACCESS 2
    checks++;
    if (ctl !== C_ACC_R0) begin
      errors++;
      $display("FAIL drop_access: ctl=%b required %b", ctl, C_ACC_R0);
    end
    req0 = 1'b1; addr0 = 16'h0200; r = 1'b1; bus_in = 16'h0ABC;
    step(); // READ
    r = 1'b0;
    step(); // ACK
    checks++;
    if (ctl !== C_ACK0 || rdata !== 16'h0ABC) begin
      errors++;
      $display("FAIL drop_ack: ctl=%b rdata=%h required %b 0ABC", ctl, rdata, C_ACK0);
    end
    step(); // IDLE
    checks++;
    if (ctl !== C_IDLE) begin
      errors++;
      $display("FAIL drop_idle_gap: ctl=%b required %b", ctl, C_IDLE);
    end
    step(); // new ADDR
    checks++;
    if (ctl !== C_ADDR_R0 || bus_out !== 16'h0200) begin
      errors++;
      $display("FAIL drop_new_addr: ctl=%b bus_out=%h required %b 0200", ctl, bus_out, C_ADDR_R0);
    end
    drain();
  endtask

  task automatic test_reset_mid_access;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; r = 1'b0;
    step(); // ADDR
    step(); // ACCESS
    checks++;
    if (mio_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_access: mio_en=%b required 1", mio_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async: ctl=%b rdata=%h required %b 0000", ctl, rdata, C_IDLE);
    end
    #2 rst_n = 1'b1;
    step(); // first edge after release: req0 wins
    checks++;
    if (ctl !== C_ADDR_R0) begin
      errors++;
      $display("FAIL rst_first_winner: ctl=%b required %b", ctl, C_ADDR_R0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_request_drop();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
